// File: rtl/bus_demultiplexer_pkg.sv
// Shared types for the bus demultiplexer: FSM state encoding and the data
// value returned on errors, write acknowledges and timeouts.
package bus_demultiplexer_pkg;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      RESP,
      DONE
   } state_t;

   // Wide enough for any practical data width; users slice [WIDTH-1:0].
   localparam int ERR_DATA_MAX_WIDTH = 1024;
   localparam logic [ERR_DATA_MAX_WIDTH-1:0] ERR_DATA = '0;

endpackage

// File: rtl/bus_demultiplexer_if.sv
// Upstream request/response and downstream fan-out signals of the demultiplexer.
// slave = view of the demultiplexer itself, master = view of the surrounding system.
interface bus_demultiplexer_if
   import bus_demultiplexer_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int CHANNELS   = 2
);
   logic                  up_req_valid;
   logic                  up_req_ready;
   logic [ADDR_WIDTH-1:0] up_req_addr;
   logic [WIDTH-1:0]      up_req_wdata;
   logic                  up_req_we;
   logic                  up_rsp_valid;
   logic [WIDTH-1:0]      up_rsp_rdata;
   logic                  up_rsp_err;

   logic [CHANNELS-1:0]   dn_req_valid;
   logic [CHANNELS-1:0]   dn_req_ready;
   logic [ADDR_WIDTH-1:0] dn_req_addr;
   logic [WIDTH-1:0]      dn_req_wdata;
   logic                  dn_req_we;
   logic [CHANNELS-1:0]   dn_rsp_valid;
   logic [WIDTH-1:0]      dn_rsp_rdata [CHANNELS];

   modport slave (
      input  up_req_valid, up_req_addr, up_req_wdata, up_req_we,
      input  dn_req_ready, dn_rsp_valid, dn_rsp_rdata,
      output up_req_ready, up_rsp_valid, up_rsp_rdata, up_rsp_err,
      output dn_req_valid, dn_req_addr, dn_req_wdata, dn_req_we
   );

   modport master (
      output up_req_valid, up_req_addr, up_req_wdata, up_req_we,
      output dn_req_ready, dn_rsp_valid, dn_rsp_rdata,
      input  up_req_ready, up_rsp_valid, up_rsp_rdata, up_rsp_err,
      input  dn_req_valid, dn_req_addr, dn_req_wdata, dn_req_we
   );

endinterface

// File: rtl/bus_demultiplexer_channel_decoder.sv
// Combinational select decoder: one-hot target vector plus a flag telling
// whether the select value names an existing channel (CHANNELS need not be 2^n).
module channel_decoder
   import bus_demultiplexer_pkg::*;
#(
   parameter int CHANNELS = 2,
   parameter int SEL_BITS = $clog2(CHANNELS)
) (
   input  logic [SEL_BITS-1:0] sel,
   output logic [CHANNELS-1:0] onehot,
   output logic                in_range
);

   genvar gi;
   generate
      for (gi = 0; gi < CHANNELS; gi++) begin : g_dec
         assign onehot[gi] = (sel == SEL_BITS'(gi));
      end
   endgenerate

   // Out-of-range selects decode to an all-zero vector, so no target is strobed.
   assign in_range = (int'(sel) < CHANNELS);

endmodule

// File: rtl/bus_demultiplexer.sv
// One-outstanding-transaction fan-out from an upstream memory bus to CHANNELS
// targets; optional watchdog enabled by defining BUS_DEMULTIPLEXER_TIMEOUT_EN.
module bus_demultiplexer
   import bus_demultiplexer_pkg::*;
#(
   parameter int WIDTH          = 32,
   parameter int ADDR_WIDTH     = 32,
   parameter int CHANNELS       = 2,
   parameter int SEL_BITS       = $clog2(CHANNELS),
   parameter int SEL_LSB        = 28,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                  clock,
   input  logic                  reset,
   bus_demultiplexer_if.slave    bus
);

   state_t                state_reg, state_next;
   logic [CHANNELS-1:0]   onehot_reg, onehot_next;
   logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
   logic [WIDTH-1:0]      wdata_reg, wdata_next;
   logic                  we_reg, we_next;
   logic [WIDTH-1:0]      rdata_reg, rdata_next;
   logic                  err_reg, err_next;

   logic [SEL_BITS-1:0]   up_sel;
   logic [CHANNELS-1:0]   up_onehot;
   logic                  up_in_range;
   logic                  req_hs, rsp_hs, timeout;
   logic [WIDTH-1:0]      rsp_masked [CHANNELS];
   logic [WIDTH-1:0]      rsp_data;

   assign up_sel = bus.up_req_addr[SEL_LSB +: SEL_BITS];

   channel_decoder #(
      .CHANNELS (CHANNELS),
      .SEL_BITS (SEL_BITS)
   ) u_decoder (
      .sel      (up_sel),
      .onehot   (up_onehot),
      .in_range (up_in_range)
   );

   // The select is kept in one-hot form so handshakes and data steering are plain masks.
   assign req_hs = |(bus.dn_req_ready & onehot_reg);
   assign rsp_hs = |(bus.dn_rsp_valid & onehot_reg);

   genvar gi;
   generate
      for (gi = 0; gi < CHANNELS; gi++) begin : g_rsp
         assign rsp_masked[gi] = onehot_reg[gi] ? bus.dn_rsp_rdata[gi] : '0;
      end
   endgenerate

   always_comb begin
      rsp_data = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         rsp_data = rsp_data | rsp_masked[i];
      end
   end

`ifdef BUS_DEMULTIPLEXER_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_reg, cnt_next;

   // Saturates at the limit so a handshake won at the limit in REQ still
   // leaves RESP guarded on its first cycle.
   always_comb begin
      cnt_next = cnt_reg;
      if (state_reg == IDLE) begin
         cnt_next = '0;
      end else if ((state_reg == REQ || state_reg == RESP) && cnt_reg != CNT_LIMIT) begin
         cnt_next = cnt_reg + 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_next;
      end
   end

   assign timeout = (cnt_reg == CNT_LIMIT);
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_next  = state_reg;
      onehot_next = onehot_reg;
      addr_next   = addr_reg;
      wdata_next  = wdata_reg;
      we_next     = we_reg;
      rdata_next  = rdata_reg;
      err_next    = err_reg;
      case (state_reg)
         IDLE: begin
            if (bus.up_req_valid) begin
               onehot_next = up_onehot;
               addr_next   = bus.up_req_addr;
               wdata_next  = bus.up_req_wdata;
               we_next     = bus.up_req_we;
               if (up_in_range) begin
                  state_next = REQ;
               end else begin
                  state_next = DONE;
                  err_next   = 1'b1;
                  rdata_next = ERR_DATA[WIDTH-1:0];
               end
            end
         end
         REQ: begin
            if (req_hs) begin
               state_next = RESP;
            end else if (timeout) begin
               state_next = DONE;
               err_next   = 1'b1;
               rdata_next = ERR_DATA[WIDTH-1:0];
            end
         end
         RESP: begin
            if (rsp_hs) begin
               state_next = DONE;
               err_next   = 1'b0;
               rdata_next = we_reg ? ERR_DATA[WIDTH-1:0] : rsp_data;
            end else if (timeout) begin
               state_next = DONE;
               err_next   = 1'b1;
               rdata_next = ERR_DATA[WIDTH-1:0];
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg  <= IDLE;
         onehot_reg <= '0;
         addr_reg   <= '0;
         wdata_reg  <= '0;
         we_reg     <= 1'b0;
         rdata_reg  <= '0;
         err_reg    <= 1'b0;
      end else begin
         state_reg  <= state_next;
         onehot_reg <= onehot_next;
         addr_reg   <= addr_next;
         wdata_reg  <= wdata_next;
         we_reg     <= we_next;
         rdata_reg  <= rdata_next;
         err_reg    <= err_next;
      end
   end

   assign bus.up_req_ready = (state_reg == IDLE);
   assign bus.up_rsp_valid = (state_reg == DONE);
   assign bus.up_rsp_rdata = rdata_reg;
   assign bus.up_rsp_err   = err_reg;
   assign bus.dn_req_valid = (state_reg == REQ) ? onehot_reg : '0;
   assign bus.dn_req_addr  = addr_reg;
   assign bus.dn_req_wdata = wdata_reg;
   assign bus.dn_req_we    = we_reg;

endmodule

// File: tb/tb_bus_demultiplexer.sv
// Self-checking bench for bus_demultiplexer (CHANNELS=3, TIMEOUT_CYCLES=8);
// watchdog scenarios run when BUS_DEMULTIPLEXER_TIMEOUT_EN is defined.
module tb_bus_demultiplexer;

   localparam int CH = 3;
   localparam int TO = 8;

   logic clock = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   bus_demultiplexer_if #(.WIDTH(32), .ADDR_WIDTH(32), .CHANNELS(CH)) bus ();

   bus_demultiplexer #(
      .WIDTH          (32),
      .ADDR_WIDTH     (32),
      .CHANNELS       (CH),
      .SEL_LSB        (28),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive_quiet();
      bus.up_req_valid = 1'b0;
      bus.up_req_addr  = $urandom;
      bus.up_req_wdata = $urandom;
      bus.up_req_we    = 1'b0;
      bus.dn_req_ready = '0;
      bus.dn_rsp_valid = '0;
      for (int i = 0; i < CH; i++) bus.dn_rsp_rdata[i] = $urandom;
   endtask

   task automatic test_reset();
      logic [CH+3:0] ctrl;
      logic [95:0]   data;
      reset = 1'b1;
      drive_quiet();
      repeat (2) tick();
      for (int k = 0; k < 2; k++) begin
         ctrl = {bus.up_req_ready, bus.up_rsp_valid, bus.up_rsp_err, bus.dn_req_we, bus.dn_req_valid};
         data = {bus.up_rsp_rdata, bus.dn_req_addr, bus.dn_req_wdata};
         total++;
         if (ctrl !== {4'b1000, {CH{1'b0}}}) begin
            bad++;
            $display("FAIL reset_ctrl[%0d] got=%b want=%b", k, ctrl, {4'b1000, {CH{1'b0}}});
         end
         total++;
         if (data !== 96'h0) begin
            bad++;
            $display("FAIL reset_data[%0d] got=%h want=0", k, data);
         end
         if (k == 0) begin
            #2 reset = 1'b0;
            tick();
         end
      end
   endtask

   // Drives one transaction with the bench acting as target; the expected
   // latency and response come from the transaction's own parameters.
   task automatic run_txn(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic we, input int d_r, input int d_s, input logic [31:0] rsp,
                          input bit xtalk, input bit early, input bit hang);
      int            sel, lat, req_end, rsp_cyc;
      bit            derr;
      logic [CH-1:0] oh;
      logic [31:0]   exp_rdata;
      logic          exp_err;
      logic [CH+1:0] obs, expc;
      logic [64:0]   obs_d;
      sel     = int'(addr[29:28]);
      derr    = (sel >= CH);
      oh      = '0;
      if (!derr) oh[sel] = 1'b1;
      rsp_cyc = 2 + d_r + d_s;
      if (derr) begin
         lat = 1; req_end = 0; exp_err = 1'b1; exp_rdata = 32'h0;
      end else if (hang) begin
         lat = TO + 1; req_end = (1 + d_r < TO) ? 1 + d_r : TO;
         exp_err = 1'b1; exp_rdata = 32'h0;
      end else begin
         lat = rsp_cyc + 1; req_end = 1 + d_r;
         exp_err = 1'b0; exp_rdata = we ? 32'h0 : rsp;
      end

      bus.up_req_valid = 1'b1;
      bus.up_req_addr  = addr;
      bus.up_req_wdata = wdata;
      bus.up_req_we    = we;
      tick();
      for (int c = 1; c <= lat + 1; c++) begin
         expc       = '0;
         expc[CH+1] = (c == lat + 1);
         expc[CH]   = (c == lat);
         if (c <= req_end) expc[CH-1:0] = oh;
         obs = {bus.up_req_ready, bus.up_rsp_valid, bus.dn_req_valid};
         total++;
         if (obs !== expc) begin
            bad++;
            $display("FAIL %s ctrl c=%0d got=%b want=%b", tag, c, obs, expc);
         end
         if (c <= req_end) begin
            obs_d = {bus.dn_req_addr, bus.dn_req_wdata, bus.dn_req_we};
            total++;
            if (obs_d !== {addr, wdata, we}) begin
               bad++;
               $display("FAIL %s dn_fields c=%0d got=%h want=%h", tag, c, obs_d, {addr, wdata, we});
            end
         end
         if (c == lat) begin
            total++;
            if ({bus.up_rsp_err, bus.up_rsp_rdata} !== {exp_err, exp_rdata}) begin
               bad++;
               $display("FAIL %s response got err=%b rdata=%h want err=%b rdata=%h",
                        tag, bus.up_rsp_err, bus.up_rsp_rdata, exp_err, exp_rdata);
            end
            $display("txn %-12s addr=%h we=%0b lat=%0d rdata=%h err=%0b",
                     tag, addr, we, lat, bus.up_rsp_rdata, bus.up_rsp_err);
         end
         // Busy-phase upstream traffic and foreign downstream strobes must be ignored.
         bus.up_req_valid = (c <= lat) ? 1'($urandom_range(0, 1)) : 1'b0;
         bus.up_req_addr  = $urandom;
         bus.up_req_wdata = $urandom;
         bus.up_req_we    = 1'($urandom_range(0, 1));
         bus.dn_req_ready = CH'($urandom);
         bus.dn_rsp_valid = '0;
         for (int i = 0; i < CH; i++) bus.dn_rsp_rdata[i] = $urandom;
         if (!derr && c < lat) begin
            bus.dn_req_ready[sel] = (c == 1 + d_r);
            if (xtalk) begin
               for (int i = 0; i < CH; i++) begin
                  if (i != sel) begin
                     bus.dn_rsp_valid[i] = 1'b1;
                     bus.dn_rsp_rdata[i] = 32'hFFFF_FFFF;
                  end
               end
            end
            if (early && c <= 1 + d_r) begin
               bus.dn_rsp_valid[sel] = 1'b1;
               bus.dn_rsp_rdata[sel] = 32'hBAD0_0000 | 32'(c);
            end
            if (!hang && c == rsp_cyc) begin
               bus.dn_rsp_valid[sel] = 1'b1;
               bus.dn_rsp_rdata[sel] = rsp;
            end
         end
         if (c <= lat) tick();
      end
   endtask

   task automatic test_read_ch1();
      run_txn("read_ch1", 32'h1000_0040, $urandom, 1'b0, 0, 0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_write_ch0();
      run_txn("write_ch0", 32'h0000_0010, 32'h1234_5678, 1'b1, 3, 0, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_decode_error();
      run_txn("decode_err", 32'h3000_0000, $urandom, 1'b0, 0, 0, 32'h1111_2222, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_crosstalk();
      run_txn("crosstalk", 32'h1000_0000, 32'h0, 1'b0, 0, 3, 32'h0000_0005, 1'b1, 1'b1, 1'b0);
   endtask

   task automatic test_back_to_back();
      for (int n = 0; n < 40; n++) begin
         run_txn("random", $urandom, $urandom, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      end
   endtask

`ifdef BUS_DEMULTIPLEXER_TIMEOUT_EN
   task automatic test_timeout();
      run_txn("timeout_rsp", 32'h2000_0004, $urandom, 1'b0, 1, 0, 32'h9999_9999, 1'b0, 1'b0, 1'b1);
      run_txn("timeout_req", 32'h1000_0008, $urandom, 1'b1, 100, 0, 32'h8888_8888, 1'b0, 1'b0, 1'b1);
      run_txn("limit_hs", 32'h0000_0100, $urandom, 1'b0, TO - 1, 0, 32'h0000_0077, 1'b0, 1'b0, 1'b0);
      run_txn("after_to_ch0", 32'h0000_0020, $urandom, 1'b0, 0, 0, 32'hA5A5_0001, 1'b0, 1'b0, 1'b0);
   endtask
`else
   task automatic test_long_wait();
      run_txn("long_wait", 32'h2000_0008, $urandom, 1'b0, 12, 20, 32'h600D_CAFE, 1'b1, 1'b0, 1'b0);
   endtask
`endif

   task automatic test_reset_mid();
      logic [CH+3:0] ctrl;
      bus.up_req_valid = 1'b1;
      bus.up_req_addr  = 32'h1000_0000;
      bus.up_req_we    = 1'b0;
      tick();
      bus.up_req_valid = 1'b0;
      bus.dn_req_ready = 3'b010;
      tick();
      bus.dn_req_ready = '0;
      total++;
      if ({bus.up_req_ready, bus.up_rsp_valid, bus.dn_req_valid} !== {2'b00, {CH{1'b0}}}) begin
         bad++;
         $display("FAIL reset_mid pre got=%b want=%b",
                  {bus.up_req_ready, bus.up_rsp_valid, bus.dn_req_valid}, {2'b00, {CH{1'b0}}});
      end
      reset = 1'b1;
      #1;
      for (int k = 0; k < 5; k++) begin
         if (k == 1) begin
            @(negedge clock);
            reset = 1'b0;
            @(posedge clock);
            #1;
            bus.dn_rsp_valid    = 3'b010;
            bus.dn_rsp_rdata[1] = 32'h0BAD_0BAD;
         end else if (k > 1) begin
            tick();
            bus.dn_rsp_valid = '0;
         end
         ctrl = {bus.up_req_ready, bus.up_rsp_valid, bus.up_rsp_err, bus.dn_req_we, bus.dn_req_valid};
         total++;
         if (ctrl !== {4'b1000, {CH{1'b0}}} ||
             {bus.up_rsp_rdata, bus.dn_req_addr, bus.dn_req_wdata} !== 96'h0) begin
            bad++;
            $display("FAIL reset_mid[%0d] got ctrl=%b data=%h want ctrl=%b data=0", k, ctrl,
                     {bus.up_rsp_rdata, bus.dn_req_addr, bus.dn_req_wdata}, {4'b1000, {CH{1'b0}}});
         end
      end
      $display("txn %-12s addr=%h dropped by reset", "reset_mid", 32'h1000_0000);
   endtask

   initial begin
      reset = 1'b1;
      test_reset();
      test_read_ch1();
      test_write_ch0();
      test_decode_error();
      test_crosstalk();
      test_back_to_back();
`ifdef BUS_DEMULTIPLEXER_TIMEOUT_EN
      test_timeout();
`else
      test_long_wait();
`endif
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bus_demultiplexer.md
# bus_demultiplexer

Routes one upstream memory-bus request to one of CHANNELS downstream targets, selected by an address field, and returns the selected target's response upstream. It is the fan-out counterpart of the data-path multiplexers: the core's data port feeds it, and RAM, MMIO and similar targets hang off it. Only one transaction is outstanding at a time. A small FSM sequences accept, forward, wait and return, with an optional watchdog.

## Interface
Parameters:
- WIDTH, 32, data width
- ADDR_WIDTH, 32, address width
- CHANNELS, 2, number of downstream targets (≥2, need not be a power of 2)
- SEL_BITS, $clog2(CHANNELS), width of the select field
- SEL_LSB, 28, lowest address bit of the select field
- TIMEOUT_CYCLES, 256, watchdog limit (≥2)

Ports:
- clock  in  1  sole clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-high
- up_req_valid  in  1  upstream request present
- up_req_ready  out  1  block can accept a request
- up_req_addr  in  ADDR_WIDTH  request address
- up_req_wdata  in  WIDTH  write data
- up_req_we  in  1  1 = write, 0 = read
- up_rsp_valid  out  1  single-cycle response strobe
- up_rsp_rdata  out  WIDTH  read data (0 for writes and errors)
- up_rsp_err  out  1  decode error or timeout
- dn_req_valid  out  CHANNELS  one-hot request strobe
- dn_req_ready  in  CHANNELS  per-target accept
- dn_req_addr  out  ADDR_WIDTH  registered address, broadcast to all targets
- dn_req_wdata  out  WIDTH  registered write data, broadcast
- dn_req_we  out  1  registered write enable, broadcast
- dn_rsp_valid  in  CHANNELS  per-target response strobe
- dn_rsp_rdata  in  WIDTH × CHANNELS (unpacked array)  per-target response data

## Operation
- Channel select: sel = up_req_addr[SEL_LSB +: SEL_BITS], captured on accept.
- States: IDLE, REQ, RESP, DONE.
- IDLE:
  - up_req_ready = 1.
  - On up_req_valid, latch addr, wdata, we and sel.
  - sel < CHANNELS → REQ.
  - sel ≥ CHANNELS → DONE, err = 1, rdata = 0, no downstream strobe.
- REQ:
  - dn_req_valid[sel] = 1; all other bits 0.
  - When dn_req_ready[sel] = 1 → RESP.
- RESP:
  - Wait for dn_rsp_valid[sel]. On it, register dn_rsp_rdata[sel] (forced to 0 when we = 1), err = 0 → DONE.
  - dn_rsp_valid on any other channel is ignored.
  - dn_rsp_valid[sel] is not sampled while in REQ.
- DONE: up_rsp_valid = 1 for exactly one cycle with the latched rdata/err → IDLE.
- Writes also receive a response (acknowledge) with rdata = 0.
- Upstream has no rsp_ready and must take the response on the strobe cycle.
- up_req_ready = 0 in REQ, RESP and DONE; up_req_valid is ignored there.

## Timing
- Reset values: state IDLE; up_req_ready 1; up_rsp_valid 0; up_rsp_rdata 0; up_rsp_err 0; dn_req_valid 0; dn_req_addr 0; dn_req_wdata 0; dn_req_we 0; watchdog counter 0.
- Best-case latency: accept at cycle N; dn_req_valid at N+1 with ready same cycle; dn_rsp_valid at N+2; up_rsp_valid at N+3.
- Decode error: up_rsp_valid at N+1.
- Next request can be accepted at the cycle after DONE.
- All outputs are registered or decoded from registered state only; no combinational path from inputs to outputs.
- Reset asserted mid-transaction: immediate return to IDLE, in-flight transaction dropped, no upstream response. Downstream responses arriving after reset are ignored, since IDLE does not sample dn_rsp_valid.

## Configuration
- Macro: BUS_DEMULTIPLEXER_TIMEOUT_EN.
- Defined:
  - Counter cleared on entry to REQ; increments each cycle in REQ and RESP.
  - If it reaches TIMEOUT_CYCLES−1 without the pending handshake → DONE with err = 1, rdata = 0, and dn_req_valid deasserted.
  - A handshake on the same cycle the limit is reached wins: normal completion.
- Undefined: no counter; REQ and RESP wait indefinitely; TIMEOUT_CYCLES is unused.

## Structure
- Package bus_demultiplexer_pkg holds:
  - the state enum typedef (IDLE, REQ, RESP, DONE);
  - the error-data constant (all zeros).
- Sub-module channel_decoder (combinational):
  - input sel, CHANNELS parameter;
  - outputs one-hot vector and in_range flag;
  - drives dn_req_valid gating and the decode-error check.

## Test plan
- Read ch1: addr 0x1000_0040, target ready immediately, rsp 0xDEAD_BEEF one cycle later → dn_req_valid = 2'b10 at N+1; up_rsp_valid at N+3, rdata 0xDEAD_BEEF, err 0.
- Write ch0: addr 0x0000_0010, wdata 0x1234_5678; ready held low 3 cycles → dn_req_valid held with stable addr/wdata/we = 1; response rdata 0, err 0.
- Decode error: CHANNELS = 3, addr 0x3000_0000 → no dn_req_valid pulse; up_rsp_valid at N+1 with err 1, rdata 0.
- Cross-talk: while waiting on ch1, pulse dn_rsp_valid[0] with 0xFFFF_FFFF → ignored; later ch1 rsp 0x5 returns 0x5.
- Reset mid-RESP: assert reset during RESP, then deliver a late dn_rsp_valid → all outputs at reset values, no up_rsp_valid, up_req_ready 1.
- Timeout (macro defined, TIMEOUT_CYCLES = 8): target never responds → up_rsp_valid with err 1 at the counter limit; subsequent read to ch0 completes normally.
